// File: rtl/serial_addsub_sequencer.sv
// Multi-cycle adder/subtractor: processes one CHUNK-bit slice of the operands per
// clock, rippling the carry between slices through a single carry flop.
//
// state | meaning
// IDLE  | waiting for start; result/carry_out/overflow hold the last operation
// BUSY  | one chunk per cycle, chunk index counts 0..N-1
// DONE  | result valid for one cycle; start here chains straight into BUSY
module serial_addsub_sequencer #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [N-1:0][CHUNK-1:0]    a_q, a_d;
    logic [N-1:0][CHUNK-1:0]    b_q, b_d;
    logic [N-1:0][CHUNK-1:0]    result_q, result_d;
    logic                       sub_q, sub_d;
    logic                       carry_q, carry_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       carry_out_q, carry_out_d;
    logic                       overflow_q, overflow_d;

    logic [CHUNK-1:0]           a_chunk;
    logic [CHUNK-1:0]           b_chunk_x;
    logic [CHUNK:0]             chunk_sum;
    logic                       chunk_ovf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        sub_d       = sub_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        // Only a CHUNK-wide adder exists; the carry flop links successive chunks.
        a_chunk   = a_q[idx_q];
        b_chunk_x = b_q[idx_q] ^ {CHUNK{sub_q}};
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk_x} + {{CHUNK{1'b0}}, carry_q};
        // Same-sign inputs producing an opposite-sign sum is equivalent to
        // carry-in XOR carry-out of the MSB.
        chunk_ovf = (a_chunk[CHUNK-1] == b_chunk_x[CHUNK-1]) &&
                    (chunk_sum[CHUNK-1] != a_chunk[CHUNK-1]);

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                result_d[idx_q] = chunk_sum[CHUNK-1:0];
                carry_d         = chunk_sum[CHUNK];
                if (idx_q == LAST_IDX) begin
                    carry_out_d = chunk_sum[CHUNK];
                    overflow_d  = chunk_ovf;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == BUSY);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_addsub_sequencer.sv
// Scoreboard bench for serial_addsub_sequencer at WIDTH=64, CHUNK=16.
module tb_serial_addsub_sequencer;

    localparam int WIDTH = 64;
    localparam int CHUNK = 16;
    localparam int N     = WIDTH / CHUNK;

    typedef struct {
        logic [63:0] res;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        busy, done, carry_out, overflow;
    logic [63:0] result;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    serial_addsub_sequencer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .reset(reset_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference: full-width arithmetic; unsigned borrow gives the inverted carry for subtraction.
    function automatic exp_t model(input logic [63:0] ia, input logic [63:0] ib, input logic isub);
        exp_t        e;
        logic [64:0] full;
        if (isub) begin
            full   = {1'b0, ia} - {1'b0, ib};
            e.cout = ~full[64];
            e.ovf  = (ia[63] != ib[63]) && (full[63] != ia[63]);
        end else begin
            full   = {1'b0, ia} + {1'b0, ib};
            e.cout = full[64];
            e.ovf  = (ia[63] == ib[63]) && (full[63] != ia[63]);
        end
        e.res = full[63:0];
        return e;
    endfunction

    task automatic issue(input logic [63:0] ia, input logic [63:0] ib, input logic isub);
        @(negedge clk);
        a = ia; b = ib; sub = isub; start = 1'b1;
        sb.push_back(model(ia, ib, isub));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called 1 time unit after the accepting edge; counts edges until done.
    task automatic wait_done(input bit disturb, output int edges, output int busy_cnt, output bit got);
        edges = 0;
        got = 1'b0;
        busy_cnt = busy ? 1 : 0;
        while (!got && edges < 20) begin
            if (disturb) begin
                if (edges < 2) begin
                    start = 1'b1;
                    a = {$urandom, $urandom};
                    b = {$urandom, $urandom};
                    sub = ~sub;
                end else begin
                    start = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            edges++;
            if (done) got = 1'b1;
            else if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start = 1'b1;
        a = 64'h1234;
        b = 64'h1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_done: got busy=%b done=%b, want 0 0", busy, done);
        end
        checks++;
        if (result !== 64'h0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got result=%h cout=%b ovf=%b, want 0", result, carry_out, overflow);
        end
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_sub_borrow;
        int   edges, bc;
        bit   got;
        exp_t e;
        issue(64'h0, 64'h1, 1'b1);
        wait_done(1'b0, edges, bc, got);
        checks++;
        if (!got || edges != N) begin
            errors++;
            $display("FAIL sub_latency: got done=%b after %0d edges, want %0d", got, edges, N);
        end
        checks++;
        if (bc != N) begin
            errors++;
            $display("FAIL sub_busy_cycles: got %0d, want %0d", bc, N);
        end
        e = sb.pop_front();
        checks++;
        if (result !== e.res || carry_out !== e.cout || overflow !== e.ovf) begin
            errors++;
            $display("FAIL sub_result: got %h c=%b v=%b, want %h c=%b v=%b",
                     result, carry_out, overflow, e.res, e.cout, e.ovf);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sub_done_pulse: got done=%b busy=%b one cycle later, want 0 0", done, busy);
        end
    endtask

    task automatic test_overflow;
        int   edges, bc;
        bit   got;
        exp_t e;
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        wait_done(1'b0, edges, bc, got);
        e = sb.pop_front();
        checks++;
        if (!got || result !== e.res || overflow !== e.ovf || carry_out !== e.cout) begin
            errors++;
            $display("FAIL ovf_result: got done=%b %h c=%b v=%b, want %h c=%b v=%b",
                     got, result, carry_out, overflow, e.res, e.cout, e.ovf);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (result !== e.res || overflow !== e.ovf || carry_out !== e.cout) begin
            errors++;
            $display("FAIL idle_hold: got %h c=%b v=%b, want %h c=%b v=%b",
                     result, carry_out, overflow, e.res, e.cout, e.ovf);
        end
    endtask

    task automatic test_chunk_carry;
        int   edges, bc;
        bit   got;
        exp_t e;
        issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        wait_done(1'b0, edges, bc, got);
        e = sb.pop_front();
        checks++;
        if (!got || result !== e.res || carry_out !== e.cout || overflow !== e.ovf) begin
            errors++;
            $display("FAIL chunk_carry: got done=%b %h c=%b v=%b, want %h c=%b v=%b",
                     got, result, carry_out, overflow, e.res, e.cout, e.ovf);
        end
    endtask

    task automatic test_back_to_back;
        int   edges, bc;
        bit   got;
        exp_t e;
        issue(64'd5, 64'd5, 1'b1);
        wait_done(1'b0, edges, bc, got);
        e = sb.pop_front();
        checks++;
        if (!got || result !== e.res || carry_out !== e.cout || overflow !== e.ovf) begin
            errors++;
            $display("FAIL b2b_first: got done=%b %h c=%b v=%b, want %h c=%b v=%b",
                     got, result, carry_out, overflow, e.res, e.cout, e.ovf);
        end
        a = 64'd3; b = 64'd7; sub = 1'b1; start = 1'b1;
        sb.push_back(model(64'd3, 64'd7, 1'b1));
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b after start in DONE, want 1", busy);
        end
        wait_done(1'b0, edges, bc, got);
        checks++;
        if (!got || edges + 1 != N + 1) begin
            errors++;
            $display("FAIL b2b_gap: got done=%b gap %0d cycles, want %0d", got, edges + 1, N + 1);
        end
        e = sb.pop_front();
        checks++;
        if (result !== e.res || carry_out !== e.cout || overflow !== e.ovf) begin
            errors++;
            $display("FAIL b2b_second: got %h c=%b v=%b, want %h c=%b v=%b",
                     result, carry_out, overflow, e.res, e.cout, e.ovf);
        end
    endtask

    task automatic test_busy_ignore;
        int   edges, bc;
        bit   got;
        exp_t e;
        issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
        wait_done(1'b1, edges, bc, got);
        checks++;
        if (!got || edges != N) begin
            errors++;
            $display("FAIL ignore_latency: got done=%b after %0d edges, want %0d", got, edges, N);
        end
        e = sb.pop_front();
        checks++;
        if (result !== e.res || carry_out !== e.cout || overflow !== e.ovf) begin
            errors++;
            $display("FAIL ignore_result: got %h c=%b v=%b, want %h c=%b v=%b",
                     result, carry_out, overflow, e.res, e.cout, e.ovf);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_restart: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid;
        int   edges, bc;
        bit   got;
        bit   seen_done;
        exp_t e;
        issue(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        void'(sb.pop_front());
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 64'h0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got busy=%b done=%b %h c=%b v=%b, want all 0",
                     busy, done, result, carry_out, overflow);
        end
        seen_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin
            errors++;
            $display("FAIL midreset_no_done: got done pulse during reset, want none");
        end
        @(negedge clk);
        reset_n = 1'b1;
        issue(64'd1, 64'd2, 1'b0);
        wait_done(1'b0, edges, bc, got);
        e = sb.pop_front();
        checks++;
        if (!got || edges != N || result !== e.res || carry_out !== e.cout || overflow !== e.ovf) begin
            errors++;
            $display("FAIL midreset_recover: got done=%b edges=%0d %h, want done after %0d edges %h",
                     got, edges, result, N, e.res);
        end
    endtask

    initial begin
        test_reset();
        test_sub_borrow();
        test_overflow();
        test_chunk_carry();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
